if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage. Owns the fetch PC, issues requests to instruction memory, and buffers returned words in a 2-entry fetch buffer.
- Presents pc/pc4/inst/bubble to the IF/ID pipeline register, which samples them every clock.
- Handles pipeline stall (hold the current slot) and branch/jump redirect (flush, refetch at target).

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- NOP_INST, 32'h0000_0013, instruction driven on inst while bubble=1 (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  downstream cannot accept; hold the presented slot.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  32  redirect target, valid when redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0, except on redirect.
- imem_ready  in  1  request accepted this cycle when imem_req & imem_ready.
- imem_rvalid  in  1  response valid; arrives at least 1 cycle after acceptance, in order.
- imem_rdata  in  32  response instruction word.
- pc  out  32  PC of presented slot.
- pc4  out  32  pc + 4.
- inst  out  32  presented instruction.
- bubble  out  1  1 = presented slot invalid (NOP).

Behaviour:
- State: fetch_pc, 2-entry FIFO of {pc, inst}, outstanding flag (0/1), drop flag, occupancy count 0..2.
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
- Outputs while rst=1 and with the FIFO empty: imem_req=0, pc=0, pc4=0, inst=NOP_INST, bubble=1.
- Output path: head of FIFO drives pc/inst combinationally; pc4 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). bubble = FIFO empty OR redirect.
- Pop: occurs at posedge when !stall && !redirect && FIFO non-empty.
- Issue rule: imem_req=1 when rst=0, drop=0, and (occupancy - pop + outstanding_after_this_cycle) < 2. At most one outstanding request. A new request may be issued in the same cycle the current one returns.
- On acceptance: outstanding=1; fetch_pc += 4 (wraps).
- On imem_rvalid with drop=0: push {addr, rdata}; outstanding=0. Push and pop in the same cycle are legal; the FIFO must never overflow.
- Throughput: 1 instruction/clk with a 1-cycle memory and no stall.
- Stall: outputs held stable every stalled cycle. Fetch continues until the FIFO is full, then imem_req=0.
- Redirect:
  - Priority over stall and pop. FIFO flushed at the posedge; fetch_pc=redirect_pc.
  - bubble=1 in the redirect cycle.
  - If a request is outstanding and rvalid is not asserted this cycle, set drop=1.
  - If rvalid is asserted in the redirect cycle, discard the data; drop stays 0.
- Drop: while drop=1, imem_req=0. The next rvalid is discarded and clears drop. Requests resume at fetch_pc the following cycle.
- Redirect while imem_req=1 but not yet accepted: imem_addr switches to redirect_pc in the same cycle; nothing is dropped.
- Back-to-back redirects: the latest redirect_pc wins.
- rst mid-operation: all state cleared at once, and any in-flight response is ignored. Memory is required to be reset together with this block.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Enabled:
  - Adds output misalign (1 bit).
  - A redirect_pc with bits[1:0] != 0 is latched as a sticky fault: misalign=1, imem_req=0, bubble=1 until rst.
  - The misaligned address is never sent to memory.
- Disabled: no port; redirect_pc[1:0] are forced to 0 before use.

Decomposition:
- Package riscv_pkg: XLEN=32, NOP_INST value, RESET_PC default, fetch_entry_t {pc[31:0], inst[31:0]}.
- One sub-module, if_fetch_fifo: 2-entry FIFO with simultaneous push/pop, flush, occupancy output.

Test Plan:
- Reset, then 1-cycle memory, no stall -> first req at RESET_PC the cycle after rst falls; pc = 0,4,8,C on consecutive cycles from cycle 3; bubble=0 steady.
- stall=1 for 4 cycles with the FIFO at pc=8 -> pc/inst held at 8; exactly 2 entries buffered (8,C); imem_req=0 after the FIFO fills; after release, pc=8 then C then 10 with no gap or duplicate.
- redirect to 0x100 while a request to 0x14 is outstanding (3-cycle memory) -> bubble=1 that cycle; the 0x14 response is discarded; next req addr=0x100; pc=0x100 presented with bubble=0.
- redirect in the same cycle as rvalid -> data discarded, drop not set; req to the target issued next cycle.
- fetch_pc=0xFFFF_FFFC -> pc4=0; next fetch address=0x0000_0000.
- IF_ALIGN_CHECK_EN, redirect to 0x102 -> misalign=1, imem_req=0, bubble=1 held until rst.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: XLEN, NOP encoding, reset PC, buffer entry layout.
// No logic; imported by the fetch stage and its buffer.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST_WORD    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// 2-entry fetch buffer with simultaneous push/pop and flush; head is combinational, 1-cycle write-to-read.
// Backpressure: a push into a full buffer without a same-cycle pop is ignored, so the producer must track count.
module if_fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset; count gates whether the head is meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns fetch PC, keeps one imem request in flight, buffers 2 words; 1 inst/clk on a 1-cycle memory.
// Backpressure: stall holds the presented slot and fetch stops once the buffer is full. Option IF_ALIGN_CHECK_EN adds misalign.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        bubble
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    logic [31:0]  fetch_pc;
    logic [31:0]  out_pc;
    logic [31:0]  tgt;
    logic         outstanding;
    logic         drop;
    logic         fault;
    logic         empty;
    logic         pop;
    logic         push;
    logic         accept;
    logic [2:0]   need;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_data;

`ifdef IF_ALIGN_CHECK_EN
    logic fault_q;

    assign tgt      = redirect_pc;
    assign fault    = fault_q || (redirect && (redirect_pc[1:0] != 2'b00));
    assign misalign = fault;

    always_ff @(posedge clk) begin
        if (rst)        fault_q <= 1'b0;
        else if (fault) fault_q <= 1'b1;
    end
`else
    assign tgt   = redirect_pc & ~32'd3;
    assign fault = 1'b0;
`endif

    assign empty = (count == 2'd0);
    assign pop   = !stall && !redirect && !empty;
    assign push  = outstanding && imem_rvalid && !drop && !redirect;
    // Slots already claimed after this cycle; the returning word is counted via outstanding.
    assign need  = {1'b0, count} - {2'b0, pop} + {2'b0, outstanding};

    always_comb begin
        imem_req = 1'b0;
        if (rst || drop || fault) begin
            imem_req = 1'b0;
        end else if (redirect) begin
            // Buffer is being flushed; only a not-yet-accepted request may retarget this cycle.
            imem_req = !outstanding;
        end else begin
            imem_req = (!outstanding || imem_rvalid) && (need < 3'd2);
        end
    end

    assign imem_addr = (redirect && !fault) ? tgt : fetch_pc;
    assign accept    = imem_req && imem_ready;

    assign push_data = '{pc: out_pc, inst: imem_rdata};

    if_fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            out_pc      <= 32'd0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (redirect)    fetch_pc <= accept ? pc_plus4(tgt) : tgt;
            else if (accept) fetch_pc <= pc_plus4(fetch_pc);

            if (accept) begin
                outstanding <= 1'b1;
                out_pc      <= imem_addr;
            end else if (imem_rvalid) begin
                outstanding <= 1'b0;
            end

            // A response already in flight at redirect belongs to the old path.
            if (imem_rvalid)                  drop <= 1'b0;
            else if (redirect && outstanding) drop <= 1'b1;
        end
    end

    assign bubble = empty || redirect || fault;
    assign pc     = empty ? 32'd0 : head.pc;
    assign pc4    = empty ? 32'd0 : pc_plus4(head.pc);
    assign inst   = bubble ? NOP_INST : head.inst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency in-order memory model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        bubble;
`ifdef IF_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;

    logic [2:0]  vp;
    logic [31:0] ap [3];

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc4         (pc4),
        .inst        (inst),
        .bubble      (bubble)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .misalign    (misalign)
`endif
    );

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    // In-order memory: an accepted request returns exactly lat cycles later.
    always @(posedge clk) begin
        if (rst) begin
            vp <= 3'b000;
        end else begin
            vp[0] <= vp[1];
            vp[1] <= vp[2];
            ap[0] <= ap[1];
            ap[1] <= ap[2];
            vp[2] <= 1'b0;
            if (imem_req && imem_ready) begin
                vp[lat-1] <= 1'b1;
                ap[lat-1] <= imem_addr;
            end
        end
    end

    assign imem_rvalid = vp[0];
    assign imem_rdata  = mw(ap[0]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // c0: reset held
        step(); #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc4", pc4, 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_bubble", {31'd0, bubble}, 32'd1);

        step(); rst = 1'b0; #1;                       // c1
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        step(); #1;                                   // c2
        chk("c2_bubble", {31'd0, bubble}, 32'd1);
        chk("c2_addr", imem_addr, 32'h4);
        step(); #1;                                   // c3
        chk("c3_pc", pc, 32'h0);
        chk("c3_bubble", {31'd0, bubble}, 32'd0);
        chk("c3_inst", inst, mw(32'h0));
        step(); #1;                                   // c4
        chk("c4_pc", pc, 32'h4);
        chk("c4_bubble", {31'd0, bubble}, 32'd0);

        step(); stall = 1'b1; #1;                     // c5..c8 stalled at pc=8
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin step(); #1; end
            chk("stall_pc", pc, 32'h8);
            chk("stall_inst", inst, mw(32'h8));
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        step(); stall = 1'b0; #1;                     // c9
        chk("rel_pc", pc, 32'h8);
        chk("rel_addr", imem_addr, 32'h10);
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        step(); lat = 3; #1;                          // c10
        chk("rel_pc_c", pc, 32'hC);
        chk("rel_bubble_c", {31'd0, bubble}, 32'd0);
        step(); #1;                                   // c11
        chk("rel_pc_10", pc, 32'h10);
        chk("c11_req", {31'd0, imem_req}, 32'd0);

        step(); redirect = 1'b1; redirect_pc = 32'h100; #1;  // c12: 0x14 in flight
        chk("redir_bubble", {31'd0, bubble}, 32'd1);
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        step(); redirect = 1'b0; #1;                  // c13: stale 0x14 returns
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        chk("drop_bubble", {31'd0, bubble}, 32'd1);
        step(); #1;                                   // c14
        chk("tgt_req", {31'd0, imem_req}, 32'd1);
        chk("tgt_addr", imem_addr, 32'h100);
        step(); lat = 1; #1;                          // c15
        chk("wait_bubble", {31'd0, bubble}, 32'd1);
        step(); #1;                                   // c16
        step(); #1;                                   // c17
        chk("c17_addr", imem_addr, 32'h104);
        step(); #1;                                   // c18
        chk("tgt_pc", pc, 32'h100);
        chk("tgt_bubble", {31'd0, bubble}, 32'd0);
        chk("tgt_inst", inst, mw(32'h100));

        step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;  // c19: rvalid same cycle
        chk("rr_bubble", {31'd0, bubble}, 32'd1);
        chk("rr_inst", inst, NOP);
        chk("rr_req", {31'd0, imem_req}, 32'd0);
        step(); redirect = 1'b0; #1;                  // c20
        chk("rr_next_req", {31'd0, imem_req}, 32'd1);
        chk("rr_next_addr", imem_addr, 32'hFFFF_FFF8);
        step(); #1;                                   // c21
        chk("wrap_addr_fc", imem_addr, 32'hFFFF_FFFC);
        step(); #1;                                   // c22
        chk("wrap_pc_f8", pc, 32'hFFFF_FFF8);
        chk("wrap_pc4_fc", pc4, 32'hFFFF_FFFC);
        chk("wrap_addr_0", imem_addr, 32'h0);
        step(); #1;                                   // c23
        chk("wrap_pc_fc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4_0", pc4, 32'h0);
        chk("wrap_inst", inst, mw(32'hFFFF_FFFC));
        step(); #1;                                   // c24
        chk("wrap_pc_0", pc, 32'h0);

        step(); rst = 1'b1; #1;                       // c25: mid-run reset
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        step(); #1;                                   // c26
        chk("mrst_pc", pc, 32'd0);
        chk("mrst_bubble", {31'd0, bubble}, 32'd1);
        chk("mrst_inst", inst, NOP);
        step(); rst = 1'b0; imem_ready = 1'b0; #1;    // c27
        chk("nr_req", {31'd0, imem_req}, 32'd1);
        chk("nr_addr", imem_addr, 32'h0);
        step(); #1;                                   // c28
        chk("nr_hold_addr", imem_addr, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h40; imem_ready = 1'b1; #1;
        chk("nr_redir_addr", imem_addr, 32'h40);
        chk("nr_redir_req", {31'd0, imem_req}, 32'd1);
        step(); redirect = 1'b0; #1;                  // c29
        chk("nr_next_addr", imem_addr, 32'h44);
        step(); #1;                                   // c30
        chk("nr_pc", pc, 32'h40);
        chk("nr_bubble", {31'd0, bubble}, 32'd0);

`ifdef IF_ALIGN_CHECK_EN
        step(); redirect = 1'b1; redirect_pc = 32'h102; #1;
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_bubble", {31'd0, bubble}, 32'd1);
        step(); redirect = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("mis_hold_flag", {31'd0, misalign}, 32'd1);
            chk("mis_hold_req", {31'd0, imem_req}, 32'd0);
            chk("mis_hold_bubble", {31'd0, bubble}, 32'd1);
            step(); #1;
        end
        rst = 1'b1;
        step(); rst = 1'b0; #1;
        chk("mis_clr_flag", {31'd0, misalign}, 32'd0);
        chk("mis_clr_req", {31'd0, imem_req}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
